branch_predict_ctrl: RTL and testbench

Branch prediction and misprediction-recovery controller for the RAT pipeline. Holds a 16-entry table of 2-bit saturating counters indexed by PC that predicts conditional branches at fetch. Takes resolved outcome and miss flag from the execute-stage branch calculator, trains the table, and sequences pipeline recovery: a PC redirect, then a timed front-end flush. Also keeps saturating branch and miss counters for performance monitoring.

---
 rtl/branch_pkg.sv | 30 +++
 rtl/branch_predict_ctrl_if.sv | 29 ++
 rtl/bht_2bit.sv | 43 ++++
 rtl/branch_predict_ctrl.sv | 93 +++++++++
 tb/tb_branch_predict_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch type codes, FSM states and helpers
package branch_pkg;

  localparam logic [3:0] BR_NONE  = 4'h0;
  localparam logic [3:0] BR_BRCC  = 4'h1;
  localparam logic [3:0] BR_BRCS  = 4'h2;
  localparam logic [3:0] BR_BREQ  = 4'h3;
  localparam logic [3:0] BR_BRN   = 4'h4;
  localparam logic [3:0] BR_BRNE  = 4'h5;
  localparam logic [3:0] BR_CALL  = 4'h6;
  localparam logic [3:0] BR_RET   = 4'h7;
  localparam logic [3:0] BR_RETID = 4'h8;
  localparam logic [3:0] BR_RETIE = 4'h9;

  localparam logic [1:0] WEAK_NT    = 2'b01;
  localparam int         FLUSH_CW   = 4;

  typedef enum logic {IDLE, RECOVER} state_t;

  function automatic logic is_conditional(input logic [3:0] br_type);
    return (br_type == BR_BRCC) || (br_type == BR_BRCS) ||
           (br_type == BR_BREQ) || (br_type == BR_BRNE);
  endfunction

  // Codes A-F are reserved and treated like BR_NONE.
  function automatic logic is_branch(input logic [3:0] br_type);
    return (br_type >= BR_BRCC) && (br_type <= BR_RETIE);
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// rtl/branch_predict_ctrl_if.sv - fetch/execute/recovery signal bundle
interface branch_predict_ctrl_if #(
  parameter int PC_WIDTH  = 10,
  parameter int CNT_WIDTH = 16
);
  logic [PC_WIDTH-1:0]  IF_PC;
  logic                 IF_IS_COND;
  logic                 PREDICT_TAKEN;
  logic                 EX_VALID;
  logic [PC_WIDTH-1:0]  EX_PC;
  logic [3:0]           EX_BRANCH_TYPE;
  logic                 EX_TAKEN;
  logic                 EX_MISS;
  logic                 PC_REDIRECT;
  logic                 FLUSH;
  logic                 BUSY;
  logic [CNT_WIDTH-1:0] BR_CNT;
  logic [CNT_WIDTH-1:0] MISS_CNT;

  modport master (
    output IF_PC, IF_IS_COND, EX_VALID, EX_PC, EX_BRANCH_TYPE, EX_TAKEN, EX_MISS,
    input  PREDICT_TAKEN, PC_REDIRECT, FLUSH, BUSY, BR_CNT, MISS_CNT
  );

  modport slave (
    input  IF_PC, IF_IS_COND, EX_VALID, EX_PC, EX_BRANCH_TYPE, EX_TAKEN, EX_MISS,
    output PREDICT_TAKEN, PC_REDIRECT, FLUSH, BUSY, BR_CNT, MISS_CNT
  );
endinterface

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - table of 2-bit saturating counters, async read, sync update
module bht_2bit
  import branch_pkg::*;
#(
  parameter int IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_WIDTH-1:0] i_rd_idx,
  output logic [1:0]           o_rd_ctr,
  input  logic                 i_wr_en,
  input  logic [IDX_WIDTH-1:0] i_wr_idx,
  input  logic                 i_wr_taken
);

  localparam int DEPTH = 2 ** IDX_WIDTH;

  logic [1:0] r_table [DEPTH];
  logic [1:0] w_wr_cur;
  logic [1:0] w_wr_next;

  // Read is straight from the array, so an update lands one cycle later.
  assign o_rd_ctr = r_table[i_rd_idx];
  assign w_wr_cur = r_table[i_wr_idx];

  always_comb begin
    w_wr_next = w_wr_cur;
    if (i_wr_taken) begin
      if (w_wr_cur != 2'b11) w_wr_next = w_wr_cur + 2'b01;
    end else begin
      if (w_wr_cur != 2'b00) w_wr_next = w_wr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= WEAK_NT;
    end else if (i_wr_en) begin
      r_table[i_wr_idx] <= w_wr_next;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - branch predictor training and misprediction recovery sequencer
module branch_predict_ctrl
  import branch_pkg::*;
#(
  parameter int PC_WIDTH     = 10,
  parameter int IDX_WIDTH    = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input logic                 CLK,
  input logic                 RST_N,
  branch_predict_ctrl_if.slave bus
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [FLUSH_CW-1:0]  r_flush_cnt;
  logic [FLUSH_CW-1:0]  w_flush_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_br_cnt;
  logic [CNT_WIDTH-1:0] r_miss_cnt;
  logic                 w_accept;
  logic                 w_train;
  logic [1:0]           w_rd_ctr;
  logic                 w_unused_pc_hi;

  // Execute holds wrong-path work during RECOVER, so nothing is accepted there.
  assign w_accept = bus.EX_VALID && (r_state == IDLE) && is_branch(bus.EX_BRANCH_TYPE);
  assign w_train  = w_accept && is_conditional(bus.EX_BRANCH_TYPE);

  assign w_unused_pc_hi = ^{bus.IF_PC[PC_WIDTH-1:IDX_WIDTH], bus.EX_PC[PC_WIDTH-1:IDX_WIDTH]};

  bht_2bit #(
    .IDX_WIDTH (IDX_WIDTH)
  ) u_bht (
    .clk        (CLK),
    .rst_n      (RST_N),
    .i_rd_idx   (bus.IF_PC[IDX_WIDTH-1:0]),
    .o_rd_ctr   (w_rd_ctr),
    .i_wr_en    (w_train),
    .i_wr_idx   (bus.EX_PC[IDX_WIDTH-1:0]),
    .i_wr_taken (bus.EX_TAKEN)
  );

  assign bus.PREDICT_TAKEN = bus.IF_IS_COND & w_rd_ctr[1];
  assign bus.PC_REDIRECT   = w_accept & bus.EX_MISS;
  assign bus.FLUSH         = (r_state == RECOVER);
  assign bus.BUSY          = (r_state == RECOVER);
  assign bus.BR_CNT        = r_br_cnt;
  assign bus.MISS_CNT      = r_miss_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept && bus.EX_MISS) begin
          w_state_nxt     = RECOVER;
          w_flush_cnt_nxt = FLUSH_CW'(FLUSH_CYCLES);
        end
      end
      RECOVER: begin
        w_flush_cnt_nxt = r_flush_cnt - 1'b1;
        if (r_flush_cnt == FLUSH_CW'(1)) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt     = IDLE;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  // Performance counters stick at all-ones rather than wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + 1'b1;
      if (bus.EX_MISS && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - scoreboard bench for branch_predict_ctrl
module tb_branch_predict_ctrl;

  localparam int PCW  = 10;
  localparam int IDXW = 4;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  branch_predict_ctrl_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bus ();

  branch_predict_ctrl #(
    .PC_WIDTH     (PCW),
    .IDX_WIDTH    (IDXW),
    .FLUSH_CYCLES (FC),
    .CNT_WIDTH    (CW)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  typedef struct {
    logic pred;
    logic redir;
    logic flush;
    logic busy;
    int   br;
    int   miss;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  int tbl[16];
  int flush_left;
  int br_m;
  int miss_m;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) tbl[i] = 1;
    flush_left = 0;
    br_m = 0;
    miss_m = 0;
  endtask

  task automatic drive(input logic ifc, input int ipc, input logic v, input int epc,
                       input int typ, input logic tk, input logic ms);
    exp_t e;
    logic acc;
    int   ix;
    @(negedge CLK);
    bus.IF_PC          = ipc[PCW-1:0];
    bus.IF_IS_COND     = ifc;
    bus.EX_VALID       = v;
    bus.EX_PC          = epc[PCW-1:0];
    bus.EX_BRANCH_TYPE = typ[3:0];
    bus.EX_TAKEN       = tk;
    bus.EX_MISS        = ms;
    acc = v && (flush_left == 0) && (typ >= 1) && (typ <= 9);
    e.pred  = ifc && (tbl[ipc % 16] >= 2);
    e.redir = acc && ms;
    e.flush = flush_left > 0;
    e.busy  = flush_left > 0;
    e.br    = br_m;
    e.miss  = miss_m;
    sb.push_back(e);
    if (flush_left > 0) flush_left--;
    if (acc) begin
      ix = epc % 16;
      if (typ == 1 || typ == 2 || typ == 3 || typ == 5) begin
        if (tk) tbl[ix] = (tbl[ix] < 3) ? tbl[ix] + 1 : 3;
        else    tbl[ix] = (tbl[ix] > 0) ? tbl[ix] - 1 : 0;
      end
      if (br_m < MAXC) br_m++;
      if (ms) begin
        if (miss_m < MAXC) miss_m++;
        flush_left = FC;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (RST_N && sb.size() > 0) begin
        e = sb.pop_front();
        chk("predict_taken", int'(bus.PREDICT_TAKEN), int'(e.pred));
        chk("pc_redirect",   int'(bus.PC_REDIRECT),   int'(e.redir));
        chk("flush",         int'(bus.FLUSH),         int'(e.flush));
        chk("busy",          int'(bus.BUSY),          int'(e.busy));
        chk("br_cnt",        int'(bus.BR_CNT),        e.br);
        chk("miss_cnt",      int'(bus.MISS_CNT),      e.miss);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.IF_PC = '0; bus.IF_IS_COND = 1'b0; bus.EX_VALID = 1'b0; bus.EX_PC = '0;
    bus.EX_BRANCH_TYPE = '0; bus.EX_TAKEN = 1'b0; bus.EX_MISS = 1'b0;
    model_reset();
    #3;
    chk("reset_flush",    int'(bus.FLUSH),    0);
    chk("reset_busy",     int'(bus.BUSY),     0);
    chk("reset_br_cnt",   int'(bus.BR_CNT),   0);
    chk("reset_miss_cnt", int'(bus.MISS_CNT), 0);
    @(negedge CLK);
    RST_N = 1'b1;

    drive(1'b1, 'h005, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 'h005, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 'h005, 1'b1, 'h015, 3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 'h005, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 'h005, 1'b1, 'h015, 3, 1'b1, 1'b0);
    drive(1'b1, 'h005, 1'b1, 'h015, 3, 1'b1, 1'b0);
    drive(1'b1, 'h005, 1'b0, 0, 0, 1'b0, 1'b0);

    drive(1'b1, 'h02A, 1'b1, 'h02A, 5, 1'b0, 1'b1);
    drive(1'b1, 'h02A, 1'b1, 'h02A, 5, 1'b1, 1'b1);
    idle(2);
    drive(1'b1, 'h02A, 1'b0, 0, 0, 1'b0, 1'b0);

    drive(1'b1, 'h003, 1'b1, 'h003, 6, 1'b1, 1'b0);
    drive(1'b1, 'h003, 1'b1, 'h007, 'hB, 1'b1, 1'b1);
    drive(1'b1, 'h007, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) drive(1'b0, 0, 1'b1, $urandom_range(0, 1023), 4, 1'b0, 1'b0);
    idle(1);
    #3;
    chk("br_cnt_saturated", int'(bus.BR_CNT), MAXC);

    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 1023),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1023),
            $urandom_range(0, 15), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 3));
    end

    idle(FC + 1);
    drive(1'b0, 0, 1'b1, 'h011, 1, 1'b1, 1'b1);
    idle(1);
    #3;
    chk("mid_recover_flush", int'(bus.FLUSH), 1);
    RST_N = 1'b0;
    #1;
    chk("async_reset_flush", int'(bus.FLUSH), 0);
    chk("async_reset_busy",  int'(bus.BUSY),  0);
    sb.delete();
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 16; i++) drive(1'b0, 0, 1'b1, i + 16 * $urandom_range(0, 63), 2, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b1, i, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
